// File: rtl/idct8x8_stream.sv
// rtl/idct8x8_stream.sv - row-serial 8x8 inverse DCT with ping-pong transpose buffer
module idct8x8_stream #(
  parameter int IW = 16,
  parameter int OW = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*IW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [8*OW-1:0] out_data,
  output logic            out_last,
  output logic            out_sat
);
  localparam logic signed [31:0] W1   = 32'sd2841;
  localparam logic signed [31:0] W2   = 32'sd2676;
  localparam logic signed [31:0] W3   = 32'sd2408;
  localparam logic signed [31:0] W5   = 32'sd1609;
  localparam logic signed [31:0] W6   = 32'sd1108;
  localparam logic signed [31:0] W7   = 32'sd565;
  localparam logic signed [31:0] SMAX = (32'sd1 <<< (OW - 1)) - 32'sd1;
  localparam logic signed [31:0] SMIN = -(32'sd1 <<< (OW - 1));

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [127:0]       mem [2][8];
  logic [1:0]         full, full_nxt;
  logic               wr_sel, rd_sel;
  logic [2:0]         wr_row, rd_col;
  logic               in_fire, cap, cap_last;
  logic [127:0]       in_ext, row_res, col_in;
  logic [255:0]       col_res;
  logic signed [31:0] col_val [8];
  logic [8*OW-1:0]    col_clip;
  logic [7:0]         clip_hit;

  // Row kernel: 16-bit coefficients in, 16-bit truncated results out
  function automatic logic [127:0] row_kernel(input logic [127:0] c);
    logic signed [31:0] b [8];
    logic signed [31:0] x0, x1, x2, x3, x4, x5, x6, x7, x8;
    logic [127:0] r;
    for (int k = 0; k < 8; k++) b[k] = {{16{c[16*k+15]}}, c[16*k +: 16]};
    r = '0;
    if ((b[1] | b[2] | b[3] | b[4] | b[5] | b[6] | b[7]) == 32'sd0) begin
      x0 = b[0] <<< 3;
      for (int k = 0; k < 8; k++) r[16*k +: 16] = 16'(x0);
    end else begin
      x0 = (b[0] <<< 11) + 32'sd128;
      x1 = b[4] <<< 11; x2 = b[6]; x3 = b[2]; x4 = b[1];
      x5 = b[7];        x6 = b[5]; x7 = b[3];
      x8 = W7 * (x4 + x5);
      x4 = x8 + (W1 - W7) * x4;
      x5 = x8 - (W1 + W7) * x5;
      x8 = W3 * (x6 + x7);
      x6 = x8 - (W3 - W5) * x6;
      x7 = x8 - (W3 + W5) * x7;
      x8 = x0 + x1; x0 = x0 - x1;
      x1 = W6 * (x3 + x2);
      x2 = x1 - (W2 + W6) * x2;
      x3 = x1 + (W2 - W6) * x3;
      x1 = x4 + x6; x4 = x4 - x6; x6 = x5 + x7; x5 = x5 - x7;
      x7 = x8 + x3; x8 = x8 - x3; x3 = x0 + x2; x0 = x0 - x2;
      x2 = (32'sd181 * (x4 + x5) + 32'sd128) >>> 8;
      x4 = (32'sd181 * (x4 - x5) + 32'sd128) >>> 8;
      r[  0 +: 16] = 16'((x7 + x1) >>> 8);
      r[ 16 +: 16] = 16'((x3 + x2) >>> 8);
      r[ 32 +: 16] = 16'((x0 + x4) >>> 8);
      r[ 48 +: 16] = 16'((x8 + x6) >>> 8);
      r[ 64 +: 16] = 16'((x8 - x6) >>> 8);
      r[ 80 +: 16] = 16'((x0 - x4) >>> 8);
      r[ 96 +: 16] = 16'((x3 - x2) >>> 8);
      r[112 +: 16] = 16'((x7 - x1) >>> 8);
    end
    return r;
  endfunction

  // Column kernel: returns full 32-bit results so clipping sees the true value
  function automatic logic [255:0] col_kernel(input logic [127:0] c);
    logic signed [31:0] b [8];
    logic signed [31:0] x0, x1, x2, x3, x4, x5, x6, x7, x8;
    logic [255:0] r;
    for (int k = 0; k < 8; k++) b[k] = {{16{c[16*k+15]}}, c[16*k +: 16]};
    r = '0;
    if ((b[1] | b[2] | b[3] | b[4] | b[5] | b[6] | b[7]) == 32'sd0) begin
      x0 = (b[0] + 32'sd32) >>> 6;
      for (int k = 0; k < 8; k++) r[32*k +: 32] = x0;
    end else begin
      x0 = (b[0] <<< 8) + 32'sd8192;
      x1 = b[4] <<< 8; x2 = b[6]; x3 = b[2]; x4 = b[1];
      x5 = b[7];       x6 = b[5]; x7 = b[3];
      x8 = W7 * (x4 + x5) + 32'sd4;
      x4 = (x8 + (W1 - W7) * x4) >>> 3;
      x5 = (x8 - (W1 + W7) * x5) >>> 3;
      x8 = W3 * (x6 + x7) + 32'sd4;
      x6 = (x8 - (W3 - W5) * x6) >>> 3;
      x7 = (x8 - (W3 + W5) * x7) >>> 3;
      x8 = x0 + x1; x0 = x0 - x1;
      x1 = W6 * (x3 + x2) + 32'sd4;
      x2 = (x1 - (W2 + W6) * x2) >>> 3;
      x3 = (x1 + (W2 - W6) * x3) >>> 3;
      x1 = x4 + x6; x4 = x4 - x6; x6 = x5 + x7; x5 = x5 - x7;
      x7 = x8 + x3; x8 = x8 - x3; x3 = x0 + x2; x0 = x0 - x2;
      x2 = (32'sd181 * (x4 + x5) + 32'sd128) >>> 8;
      x4 = (32'sd181 * (x4 - x5) + 32'sd128) >>> 8;
      r[  0 +: 32] = (x7 + x1) >>> 14;
      r[ 32 +: 32] = (x3 + x2) >>> 14;
      r[ 64 +: 32] = (x0 + x4) >>> 14;
      r[ 96 +: 32] = (x8 + x6) >>> 14;
      r[128 +: 32] = (x8 - x6) >>> 14;
      r[160 +: 32] = (x0 - x4) >>> 14;
      r[192 +: 32] = (x3 - x2) >>> 14;
      r[224 +: 32] = (x7 - x1) >>> 14;
    end
    return r;
  endfunction

  assign in_ready = !full[wr_sel];
  assign in_fire  = in_valid && in_ready;
  // Column 0 may be captured straight from IDLE so the first beat lands one edge after the fill
  assign cap      = full[rd_sel] && (!out_valid || out_ready);
  assign cap_last = cap && (rd_col == 3'd7);

  // Sign-extend input lanes and run the row kernel
  always_comb begin
    for (int k = 0; k < 8; k++) in_ext[16*k +: 16] = 16'($signed(in_data[IW*k +: IW]));
    row_res = row_kernel(in_ext);
  end

  // Gather column rd_col of the read bank, run the column kernel and clip each lane
  always_comb begin
    col_clip = '0;
    clip_hit = '0;
    for (int r = 0; r < 8; r++) col_in[16*r +: 16] = mem[rd_sel][r][{rd_col, 4'b0000} +: 16];
    col_res = col_kernel(col_in);
    for (int r = 0; r < 8; r++) begin
      col_val[r] = col_res[32*r +: 32];
      if (col_val[r] > SMAX) begin
        col_clip[OW*r +: OW] = SMAX[OW-1:0];
        clip_hit[r] = 1'b1;
      end else if (col_val[r] < SMIN) begin
        col_clip[OW*r +: OW] = SMIN[OW-1:0];
        clip_hit[r] = 1'b1;
      end else begin
        col_clip[OW*r +: OW] = col_val[r][OW-1:0];
      end
    end
  end

  // Bank occupancy and column-engine next state
  always_comb begin
    full_nxt  = full;
    state_nxt = state;
    if (in_fire && wr_row == 3'd7) full_nxt[wr_sel] = 1'b1;
    if (cap_last) full_nxt[rd_sel] = 1'b0;
    case (state)
      IDLE: if (full[rd_sel]) state_nxt = RUN;
      RUN:  if (cap_last) state_nxt = full[~rd_sel] ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transpose buffer write; contents need no reset because full gates every read
  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_sel][wr_row] <= row_res;
  end

  // Row/column counters, bank selects, occupancy and FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_row <= '0;
      rd_col <= '0;
    end else begin
      state <= state_nxt;
      full  <= full_nxt;
      if (in_fire) begin
        wr_row <= wr_row + 3'd1;
        if (wr_row == 3'd7) wr_sel <= ~wr_sel;
      end
      if (cap) begin
        rd_col <= rd_col + 3'd1;
        if (cap_last) rd_sel <= ~rd_sel;
      end
    end
  end

  // Output register: load on capture, otherwise hold until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (cap) begin
      out_valid <= 1'b1;
      out_data  <= col_clip;
      out_last  <= (rd_col == 3'd7);
      out_sat   <= |clip_hit;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
